// File: rtl/vec_index_decoder_pkg.sv
// Shared lane geometry, lane encoder/decoder functions and handshake state type
// for the vector index encode/decode path.
package vec_index_decoder_pkg;

  localparam int unsigned VEC_NUM_LANES = 4;
  localparam int unsigned VEC_LANE_W    = 8;
  localparam int unsigned VEC_IDX_W     = 3;
  localparam int unsigned VEC_CNT_W     = 16;

  typedef struct packed {
    logic [VEC_NUM_LANES*VEC_LANE_W-1:0] vec_in;
    logic [VEC_IDX_W-1:0]                left;
    logic [VEC_IDX_W-1:0]                right;
  } encoder_func_in;

  typedef struct packed {
    logic [VEC_IDX_W-1:0] vec_index;
    logic                 valid;
  } encoder_func_out;

  typedef struct packed {
    logic [VEC_LANE_W-1:0] vec_in;
    logic [VEC_IDX_W-1:0]  index;
    logic [VEC_IDX_W-1:0]  left;
    logic [VEC_IDX_W-1:0]  right;
  } decoder_func_in;

  typedef struct packed {
    logic [VEC_NUM_LANES-1:0]            onehot;
    logic [VEC_NUM_LANES*VEC_LANE_W-1:0] vec_out;
    logic                                err;
  } decoder_func_out;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;

  // Lowest non-zero lane inside [left, right]; descending scan lets the lowest lane win.
  function automatic encoder_func_out encoder_function(input encoder_func_in f);
    encoder_func_out r;
    r = '0;
    for (int unsigned k = VEC_NUM_LANES; k > 0; k--) begin
      if (VEC_IDX_W'(k - 1) >= f.left && VEC_IDX_W'(k - 1) <= f.right &&
          f.vec_in[(k - 1)*VEC_LANE_W +: VEC_LANE_W] != '0) begin
        r.vec_index = VEC_IDX_W'(k - 1);
        r.valid     = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic decoder_func_out decoder_function(input decoder_func_in f);
    decoder_func_out r;
    logic            ok;
    r  = '0;
    ok = (f.left <= f.right) && (f.index >= f.left) && (f.index <= f.right) &&
         (32'(f.index) < VEC_NUM_LANES);
    for (int unsigned k = 0; k < VEC_NUM_LANES; k++) begin
      if (ok && f.index == VEC_IDX_W'(k)) begin
        r.onehot[k]                          = 1'b1;
        r.vec_out[k*VEC_LANE_W +: VEC_LANE_W] = f.vec_in;
      end
    end
    r.err = !ok;
    return r;
  endfunction

endpackage

// File: rtl/vec_index_decoder_skid.sv
// Output register plus one-entry skid buffer; in_ready is registered so no
// combinational path runs from out_ready back to in_ready.
module vec_skid_buffer
  import vec_index_decoder_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  decoder_func_out in_payload,
  output logic            out_valid,
  input  logic            out_ready,
  output decoder_func_out out_payload
);

  skid_state_e     state, state_nxt;
  decoder_func_out out_q, skid_q;
  logic            ready_q;
  logic            accept, drain;
  logic            load_out, load_skid, skid_to_out;

  assign accept      = in_valid && ready_q;
  assign drain       = (state != EMPTY) && out_ready;
  assign in_ready    = ready_q;
  assign out_valid   = (state != EMPTY);
  assign out_payload = out_q;

  always_comb begin
    state_nxt   = state;
    load_out    = 1'b0;
    load_skid   = 1'b0;
    skid_to_out = 1'b0;
    case (state)
      EMPTY: if (accept) begin
        state_nxt = ONE;
        load_out  = 1'b1;
      end
      ONE: begin
        if (accept && drain) begin
          load_out = 1'b1;
        end else if (accept) begin
          state_nxt = TWO;
          load_skid = 1'b1;
        end else if (drain) begin
          state_nxt = EMPTY;
        end
      end
      TWO: if (drain) begin
        state_nxt   = ONE;
        skid_to_out = 1'b1;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != TWO);
      if (load_out)         out_q <= in_payload;
      else if (skid_to_out) out_q <= skid_q;
      if (load_skid)        skid_q <= in_payload;
    end
  end

endmodule

// File: rtl/vec_index_decoder.sv
// Lane index decoder: rebuilds a one-hot select and lane vector from an index
// and data byte, registered through a skid-buffered valid/ready stream.
module vec_index_decoder
  import vec_index_decoder_pkg::*;
#(
  // Payload types come from the package, so these must match its VEC_* values.
  parameter int unsigned NUM_LANES = VEC_NUM_LANES,
  parameter int unsigned LANE_W    = VEC_LANE_W,
  parameter int unsigned IDX_W     = VEC_IDX_W,
  parameter int unsigned CNT_W     = VEC_CNT_W
)(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IDX_W-1:0]            in_index,
  input  logic [IDX_W-1:0]            in_left,
  input  logic [IDX_W-1:0]            in_right,
  input  logic [LANE_W-1:0]           in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_onehot,
  output logic [NUM_LANES*LANE_W-1:0] out_vec,
  output logic                        out_err,
  output logic [CNT_W-1:0]            dec_count
);

  decoder_func_in  dec_in;
  decoder_func_out dec_res, held;

  always_comb begin
    dec_in.vec_in = in_data;
    dec_in.index  = in_index;
    dec_in.left   = in_left;
    dec_in.right  = in_right;
    dec_res       = decoder_function(dec_in);
  end

  vec_skid_buffer u_skid (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  (dec_res),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (held)
  );

  assign out_onehot = held.onehot;
  assign out_vec    = held.vec_out;
  assign out_err    = held.err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dec_count <= '0;
    else if (out_valid && out_ready) dec_count <= dec_count + 1'b1;
  end

endmodule

// File: tb/tb_vec_index_decoder.sv
// Bench for vec_index_decoder: directed vector table, backpressure and reset
// sequences, randomized streaming against a queue model, and encoder round trip.
module tb_vec_index_decoder;
  import vec_index_decoder_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_index = '0, in_left = '0, in_right = '0;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_onehot;
  logic [31:0] out_vec;
  logic        out_err;
  logic [15:0] dec_count;

  vec_index_decoder #(.NUM_LANES(4), .LANE_W(8), .IDX_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_left(in_left), .in_right(in_right), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_onehot(out_onehot),
    .out_vec(out_vec), .out_err(out_err), .dec_count(dec_count)
  );

  always #5 clk = ~clk;

  typedef struct { bit [3:0] oh; bit [31:0] vec; bit err; } res_t;
  typedef struct {
    int idx; int l; int r; int d;
    bit [3:0] oh; bit [31:0] vec; bit err;
  } vec_t;

  int          errors = 0, checks = 0;
  res_t        q[$];
  bit          exp_in_ready = 1'b0;
  logic [15:0] exp_count = '0;
  int          accepted = 0;

  function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  // Reference decode straight from the lane rules.
  function automatic res_t ref_decode(int idx, int l, int r, int d);
    res_t x;
    x.oh = '0; x.vec = '0; x.err = 1'b1;
    if (l <= r && idx >= l && idx <= r && idx < 4) begin
      x.oh  = 4'(1 << idx);
      x.vec = 32'(d) << (8 * idx);
      x.err = 1'b0;
    end
    return x;
  endfunction

  task automatic tick();
    bit   acc, drn;
    res_t e;
    acc = in_valid && exp_in_ready;
    drn = (q.size() != 0) && out_ready;
    e   = ref_decode(int'(in_index), int'(in_left), int'(in_right), int'(in_data));
    @(posedge clk); #1;
    if (drn) begin void'(q.pop_front()); exp_count++; end
    if (acc) begin q.push_back(e); accepted++; end
    exp_in_ready = (q.size() < 2);
    chk("in_ready", in_ready, exp_in_ready);
    chk("out_valid", out_valid, q.size() != 0);
    chk("dec_count", dec_count, exp_count);
    if (q.size() != 0) begin
      chk("onehot", out_onehot, q[0].oh);
      chk("vec", out_vec, q[0].vec);
      chk("err", out_err, q[0].err);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_vec", out_vec, 32'h0);
    chk("rst_onehot", out_onehot, 4'h0);
    chk("rst_err", out_err, 1'b0);
    chk("rst_dec_count", dec_count, 16'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    exp_in_ready = 1'b0;
    exp_count = '0;
  endtask

  task automatic drive(int idx, int l, int r, int d);
    in_index = 3'(idx); in_left = 3'(l); in_right = 3'(r); in_data = 8'(d);
  endtask

  vec_t tv[7];
  encoder_func_in  ein;
  encoder_func_out eout;

  initial begin
    tv[0] = '{2, 1, 3, 8'hA5, 4'b0100, 32'h00A5_0000, 1'b0};
    tv[1] = '{0, 1, 3, 8'h5A, 4'b0000, 32'h0, 1'b1};
    tv[2] = '{2, 3, 1, 8'h77, 4'b0000, 32'h0, 1'b1};
    tv[3] = '{5, 0, 7, 8'h12, 4'b0000, 32'h0, 1'b1};
    tv[4] = '{0, 0, 3, 8'h11, 4'b0001, 32'h0000_0011, 1'b0};
    tv[5] = '{3, 0, 3, 8'hFF, 4'b1000, 32'hFF00_0000, 1'b0};
    tv[6] = '{1, 1, 1, 8'h3C, 4'b0010, 32'h0000_3C00, 1'b0};

    #12;
    do_reset();
    tick();
    chk("in_ready_after_release", in_ready, 1'b1);

    // Directed vector table, one request at a time with out_ready high.
    out_ready = 1'b1;
    foreach (tv[i]) begin
      drive(tv[i].idx, tv[i].l, tv[i].r, tv[i].d);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      chk("tbl_valid", out_valid, 1'b1);
      chk("tbl_onehot", out_onehot, tv[i].oh);
      chk("tbl_vec", out_vec, tv[i].vec);
      chk("tbl_err", out_err, tv[i].err);
      chk("tbl_count", dec_count, 16'(i));
      tick();
    end
    chk("tbl_final_count", dec_count, 16'd7);

    // Backpressure: idx1 then idx3 with the output stalled.
    out_ready = 1'b0;
    drive(1, 0, 3, 8'h21); in_valid = 1'b1; tick();
    drive(3, 0, 3, 8'h43); tick();
    in_valid = 1'b0;
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_hold_onehot", out_onehot, 4'b0010);
    tick(); tick();
    chk("bp_still_held", out_vec, 32'h0000_2100);
    out_ready = 1'b1;
    tick();
    chk("bp_second_onehot", out_onehot, 4'b1000);
    chk("bp_second_vec", out_vec, 32'h4300_0000);
    chk("bp_in_ready_high", in_ready, 1'b1);
    tick();
    chk("bp_empty", out_valid, 1'b0);

    // Reset mid-traffic with both entries occupied.
    out_ready = 1'b0;
    drive(0, 0, 3, 8'h99); in_valid = 1'b1; tick();
    drive(2, 0, 3, 8'h98); tick();
    in_valid = 1'b0;
    #2;
    do_reset();
    tick();
    chk("post_reset_no_stale", out_valid, 1'b0);

    // Randomized streaming: 100 requests, random backpressure.
    accepted = 0;
    in_valid = 1'b1;
    drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
    for (int cyc = 0; cyc < 2000 && (accepted < 100 || q.size() != 0); cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (accepted >= 100) in_valid = 1'b0;
      tick();
      if (exp_in_ready)
        drive($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255));
    end
    in_valid = 1'b0;
    chk("stream_accepted", 64'(accepted), 64'd100);
    chk("stream_drained", 64'(q.size()), 64'd0);
    chk("stream_count", dec_count, 16'd100);

    // Round trip through the lane encoder.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(i, 0, 3, $urandom_range(1, 255));
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      ein.vec_in = out_vec; ein.left = 3'd0; ein.right = 3'd3;
      eout = encoder_function(ein);
      chk("roundtrip_index", eout.vec_index, 3'(i));
      chk("roundtrip_valid", eout.valid, 1'b1);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
